dcache_wt: RTL and testbench

DCACHE_WT -- requirements
Module: dcache_wt

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_sat_counter.sv | 35 +++
 rtl/dcache_wt.sv | 225 ++++++++++++++++++++++
 tb/tb_dcache_wt.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-split width helpers for the write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FLUSH  = 2'd3
   } state_e;

   function automatic int off_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int word_bits(input int words);
      return $clog2(words);
   endfunction

   function automatic int index_bits(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_bits(input int addr_w, input int data_w,
                                   input int words, input int lines);
      return addr_w - off_bits(data_w) - word_bits(words) - index_bits(lines);
   endfunction

endpackage

// File: rtl/dcache_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module dcache_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // next count: increment unless already saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with hit/miss statistics.
module dcache_wt
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   parameter int WORDS  = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_busy,
   output logic              cpu_hit,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int OFF_W   = off_bits(DATA_W);
   localparam int WORD_W  = word_bits(WORDS);
   localparam int IDX_W   = index_bits(LINES);
   localparam int TAG_W   = tag_bits(ADDR_W, DATA_W, WORDS, LINES);
   localparam int WSEL_W  = (WORD_W > 0) ? WORD_W : 1;
   localparam int DA_W    = IDX_W + WORD_W;
   localparam int LINE_SH = OFF_W + WORD_W;
   localparam int TAG_SH  = LINE_SH + IDX_W;

   logic [DATA_W-1:0] data_mem [LINES*WORDS];
   logic [TAG_W-1:0]  tag_mem  [LINES];

   state_e            state_q, state_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [WSEL_W-1:0] beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              flush_pend_q, flush_pend_d;
   logic              retry_q, retry_d;

   logic [IDX_W-1:0]  cpu_idx, ref_idx;
   logic [TAG_W-1:0]  cpu_tag, ref_tag;
   logic [DA_W-1:0]   cpu_da, ref_da;
   logic [ADDR_W-1:0] line_base;
   logic              lookup_hit;

   logic              busy_s, hit_inc, miss_inc, mem_req_s, mem_we_s;
   logic              dwe_s, twe_s;
   logic [DA_W-1:0]   dwaddr_s;
   logic [DATA_W-1:0] dwdata_s;

   // index and word fields sit contiguously above the byte offset
   assign cpu_idx    = IDX_W'(cpu_addr >> LINE_SH);
   assign cpu_tag    = TAG_W'(cpu_addr >> TAG_SH);
   assign cpu_da     = DA_W'(cpu_addr >> OFF_W);
   assign ref_idx    = IDX_W'(addr_q >> LINE_SH);
   assign ref_tag    = TAG_W'(addr_q >> TAG_SH);
   assign ref_da     = (DA_W'(addr_q >> LINE_SH) << WORD_W) | DA_W'(beat_q);
   assign line_base  = (addr_q >> LINE_SH) << LINE_SH;
   assign lookup_hit = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

   assign cpu_rdata  = data_mem[cpu_da];
   assign mem_addr   = (state_q == ST_REFILL) ? (line_base | (ADDR_W'(beat_q) << OFF_W)) : addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_req    = reset & mem_req_s;
   assign mem_we     = reset & mem_we_s;
   assign cpu_busy   = reset & busy_s;
   assign cpu_hit    = reset & hit_inc;

   // next-state, array write controls and handshake outputs
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      beat_d       = beat_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      flush_pend_d = flush_pend_q;
      retry_d      = 1'b0;
      busy_s       = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      mem_req_s    = 1'b0;
      mem_we_s     = 1'b0;
      dwe_s        = 1'b0;
      twe_s        = 1'b0;
      dwaddr_s     = cpu_da;
      dwdata_s     = cpu_wdata;
      case (state_q)
         ST_IDLE: begin
            if (flush || flush_pend_q) begin
               busy_s       = 1'b1;
               flush_pend_d = 1'b0;
               retry_d      = retry_q;
               state_d      = ST_FLUSH;
            end else if (cpu_req) begin
               // a request held across a completed refill/write retires uncounted
               if (retry_q && (cpu_we || lookup_hit)) begin
                  busy_s = 1'b0;
               end else if (cpu_we) begin
                  busy_s   = 1'b1;
                  hit_inc  = lookup_hit;
                  miss_inc = ~lookup_hit;
                  dwe_s    = lookup_hit;
                  addr_d   = cpu_addr;
                  wdata_d  = cpu_wdata;
                  state_d  = ST_WRITE;
               end else if (lookup_hit) begin
                  hit_inc = ~retry_q;
               end else begin
                  busy_s           = 1'b1;
                  miss_inc         = 1'b1;
                  addr_d           = cpu_addr;
                  beat_d           = '0;
                  valid_d[cpu_idx] = 1'b0;
                  state_d          = ST_REFILL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REFILL: begin
            busy_s    = 1'b1;
            mem_req_s = 1'b1;
            if (mem_ack) begin
               dwe_s    = 1'b1;
               dwaddr_s = ref_da;
               dwdata_s = mem_rdata;
               beat_d   = beat_q + WSEL_W'(1);
               if (beat_q == WSEL_W'(WORDS - 1)) begin
                  twe_s            = 1'b1;
                  valid_d[ref_idx] = 1'b1;
                  retry_d          = 1'b1;
                  beat_d           = '0;
                  state_d          = ST_IDLE;
               end else begin
                  state_d = ST_REFILL;
               end
            end else begin
               state_d = ST_REFILL;
            end
         end
         ST_WRITE: begin
            busy_s    = 1'b1;
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            if (mem_ack) begin
               retry_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_FLUSH: begin
            busy_s  = 1'b1;
            valid_d = '0;
            retry_d = retry_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush && (state_q != ST_IDLE)) begin
         flush_pend_d = 1'b1;
      end else begin
         flush_pend_d = flush_pend_d;
      end
   end

   // control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         valid_q      <= '0;
         beat_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         flush_pend_q <= 1'b0;
         retry_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         beat_q       <= beat_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         flush_pend_q <= flush_pend_d;
         retry_q      <= retry_d;
      end
   end

   // data and tag arrays are deliberately not reset
   always_ff @(posedge clk) begin
      if (reset && dwe_s) begin
         data_mem[dwaddr_s] <= dwdata_s;
      end
      if (reset && twe_s) begin
         tag_mem[ref_idx] <= ref_tag;
      end
   end

   dcache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hit_inc),
      .count (hit_count)
   );

   dcache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: expected memory beats and CPU completions are queued by the stimulus.
module tb_dcache_wt;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [31:0]   cpu_addr = 32'd0;
   logic [31:0]   cpu_wdata = 32'd0;
   logic [31:0]   cpu_rdata;
   logic          cpu_busy;
   logic          cpu_hit;
   logic          flush = 1'b0;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = 32'd0;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;

   dcache_wt #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS(4), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_busy(cpu_busy), .cpu_hit(cpu_hit), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_t;

   typedef struct {
      logic        we;
      logic [31:0] data;
      logic        hit;
   } resp_t;

   mem_t        exp_mem[$];
   resp_t       exp_resp[$];
   logic [31:0] mem_arr [logic [31:0]];
   int          total = 0;
   int          bad = 0;
   int          rd_lat = 0;
   int          wr_lat = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] data);
      mem_t m;
      m.we = we; m.addr = addr; m.data = data;
      exp_mem.push_back(m);
   endtask

   task automatic push_refill(input logic [31:0] base);
      for (int i = 0; i < 4; i++) push_mem(1'b0, base + 32'(4 * i), 32'd0);
   endtask

   task automatic push_resp(input logic we, input logic [31:0] data, input logic hit);
      resp_t r;
      r.we = we; r.data = data; r.hit = hit;
      exp_resp.push_back(r);
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return 32'hB000_0000 | a;
   endfunction

   // backing memory: acks after rd_lat/wr_lat wait cycles, stores written data
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req) begin
            if (wait_cnt >= (mem_we ? wr_lat : rd_lat)) begin
               mem_ack = 1'b1;
               mem_rdata = mem_read(mem_addr);
               if (mem_we) mem_arr[mem_addr] = mem_wdata;
               wait_cnt = 0;
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // monitor: compares memory beats and CPU completions against the queues
   initial begin
      mem_t  m;
      resp_t r;
      forever begin
         @(negedge clk);
         if (reset && mem_req && mem_ack) begin
            if (exp_mem.size() == 0) begin
               total++; bad++;
               $display("FAIL mem_beat: unexpected beat we=%0b addr=%h", mem_we, mem_addr);
            end else begin
               m = exp_mem.pop_front();
               check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
               check("mem_addr", mem_addr, m.addr);
               if (m.we) check("mem_wdata", mem_wdata, m.data);
            end
         end
         if (reset && cpu_req && !cpu_busy) begin
            if (exp_resp.size() == 0) begin
               total++; bad++;
               $display("FAIL cpu_done: unexpected completion addr=%h", cpu_addr);
            end else begin
               r = exp_resp.pop_front();
               check("cpu_hit", {31'd0, cpu_hit}, {31'd0, r.hit});
               if (!r.we) check("cpu_rdata", cpu_rdata, r.data);
            end
         end
      end
   end

   task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic with_flush, output int busy_cyc);
      bit done;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; flush = with_flush;
      busy_cyc = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!cpu_busy) begin
            done = 1'b1;
         end else begin
            busy_cyc++;
            if (flush) begin
               @(posedge clk); #1;
               flush = 1'b0;
            end
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL cpu_timeout: addr=%h still busy after %0d cycles", addr, busy_cyc);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
   endtask

   initial begin
      int bc;
      int acks;
      for (int i = 0; i < 4; i++) mem_arr[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);

      // reset with a request pending: nothing may leave the block
      cpu_req = 1'b1; cpu_addr = 32'h40;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_busy", {31'd0, cpu_busy}, 32'd0);
      check("rst_hit", {31'd0, cpu_hit}, 32'd0);
      check("rst_hit_count", {28'd0, hit_count}, 32'd0);
      check("rst_miss_count", {28'd0, miss_count}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; cpu_req = 1'b0;

      // cold load 0x40
      push_refill(32'h40);
      push_resp(1'b0, 32'hA0, 1'b0);
      cpu_op(1'b0, 32'h40, 32'd0, 1'b0, bc);
      check("cold_busy", bc, 32'd5);
      check("cold_hits", {28'd0, hit_count}, 32'd0);
      check("cold_miss", {28'd0, miss_count}, 32'd1);

      // same-cycle hit
      push_resp(1'b0, 32'hA1, 1'b1);
      cpu_op(1'b0, 32'h44, 32'd0, 1'b0, bc);
      check("hit_busy", bc, 32'd0);
      check("hit_hits", {28'd0, hit_count}, 32'd1);

      // store hit with slow memory ack
      wr_lat = 2;
      push_mem(1'b1, 32'h48, 32'h55);
      push_resp(1'b1, 32'd0, 1'b0);
      cpu_op(1'b1, 32'h48, 32'h55, 1'b0, bc);
      check("sthit_busy", bc, 32'd4);
      check("sthit_hits", {28'd0, hit_count}, 32'd2);
      check("sthit_miss", {28'd0, miss_count}, 32'd1);
      wr_lat = 0;
      push_resp(1'b0, 32'h55, 1'b1);
      cpu_op(1'b0, 32'h48, 32'd0, 1'b0, bc);
      check("ld_after_st_busy", bc, 32'd0);
      check("ld_after_st_hits", {28'd0, hit_count}, 32'd3);

      // store miss: no allocate, later load refills
      push_mem(1'b1, 32'h400, 32'h77);
      push_resp(1'b1, 32'd0, 1'b0);
      cpu_op(1'b1, 32'h400, 32'h77, 1'b0, bc);
      check("stmiss_busy", bc, 32'd2);
      check("stmiss_miss", {28'd0, miss_count}, 32'd2);
      push_refill(32'h400);
      push_resp(1'b0, 32'h77, 1'b0);
      cpu_op(1'b0, 32'h400, 32'd0, 1'b0, bc);
      check("ld400_busy", bc, 32'd5);
      check("ld400_miss", {28'd0, miss_count}, 32'd3);

      // flush together with a load: one FLUSH cycle, then miss and refill
      push_refill(32'h40);
      push_resp(1'b0, 32'hA0, 1'b0);
      cpu_op(1'b0, 32'h40, 32'd0, 1'b1, bc);
      check("flush_busy", bc, 32'd7);
      check("flush_hits", {28'd0, hit_count}, 32'd3);
      check("flush_miss", {28'd0, miss_count}, 32'd4);
      push_resp(1'b0, 32'h55, 1'b1);
      cpu_op(1'b0, 32'h48, 32'd0, 1'b0, bc);
      check("refill_wt_hits", {28'd0, hit_count}, 32'd4);

      // reset in the middle of a refill
      push_mem(1'b0, 32'hC0, 32'd0);
      push_mem(1'b0, 32'hC4, 32'd0);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC0;
      acks = 0;
      for (int i = 0; i < 50 && acks < 2; i++) begin
         @(negedge clk);
         if (mem_req && mem_ack) acks++;
      end
      check("abort_acks", acks, 32'd2);
      @(posedge clk); #1;
      reset = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      check("abort_mem_req", {31'd0, mem_req}, 32'd0);
      check("abort_busy", {31'd0, cpu_busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("abort_hits", {28'd0, hit_count}, 32'd0);
      check("abort_miss", {28'd0, miss_count}, 32'd0);
      push_refill(32'hC0);
      push_resp(1'b0, 32'hB000_00C4, 1'b0);
      cpu_op(1'b0, 32'hC4, 32'd0, 1'b0, bc);
      check("reload_busy", bc, 32'd5);
      check("reload_miss", {28'd0, miss_count}, 32'd1);

      // hit counter saturation
      for (int i = 0; i < 17; i++) begin
         push_resp(1'b0, 32'hB000_00C0, 1'b1);
         cpu_op(1'b0, 32'hC0, 32'd0, 1'b0, bc);
         if (i == 13) check("hits_14", {28'd0, hit_count}, 32'd14);
         if (i == 15) check("hits_sat", {28'd0, hit_count}, 32'd15);
      end
      check("hits_stay", {28'd0, hit_count}, 32'd15);

      // miss counter saturation through uncached stores
      for (int i = 0; i < 16; i++) begin
         push_mem(1'b1, 32'h2000 + 32'(4 * i), 32'(i));
         push_resp(1'b1, 32'd0, 1'b0);
         cpu_op(1'b1, 32'h2000 + 32'(4 * i), 32'(i), 1'b0, bc);
         if (i == 12) check("miss_14", {28'd0, miss_count}, 32'd14);
         if (i == 14) check("miss_sat", {28'd0, miss_count}, 32'd15);
      end
      check("miss_stay", {28'd0, miss_count}, 32'd15);

      repeat (3) @(posedge clk);
      check("mem_queue_left", exp_mem.size(), 32'd0);
      check("resp_queue_left", exp_resp.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
